// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: synchronizes RX, finds the start edge, samples mid-bit,
// and reports each byte with a one-cycle strobe (or a one-cycle framing-error strobe).
module uart_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       res,
   input  logic       RX,
   output logic [7:0] data_out,
   output logic       en_data_out,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned HALF = CLKS_PER_BIT >> 1;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   vld_q;
   logic                   rx_q;
   logic                   rx_s;
   logic                   fall;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             sh_q, sh_d;
   logic [7:0]             data_q, data_d;
   logic                   en_q, en_d;
   logic                   fe_q, fe_d;

   assign rx_s = sync_q[SYNC_STAGES-1];
   // vld_q fills once the preset ones have drained from the synchronizer, so a line
   // already low at reset release is not mistaken for a start edge.
   assign fall = vld_q[SYNC_STAGES] & rx_q & ~rx_s;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         sync_q  <= '1;
         rx_q    <= 1'b1;
         vld_q   <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
         rx_q    <= rx_s;
         vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         en_q    <= en_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      en_d    = 1'b0;
      fe_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rx_s) begin
                  data_d = sh_q;
                  en_d   = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data_out    = data_q;
   assign en_data_out = en_q;
   assign frame_err   = fe_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 8 clk/bit: bit-accurate RX driver, a small
// clocked transmitter for loopback, and a negedge strobe monitor.
module tb_uart_rx_deframer;

   localparam int unsigned CPB = 8;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       rx_bfm = 1'b1;
   logic       loop = 1'b0;
   logic       rx_w;
   logic [7:0] data_out;
   logic       en_data_out;
   logic       frame_err;
   logic       busy;

   int         pass_cnt = 0;
   int         chk_cnt = 0;
   int         cyc = 0;
   int         t_fall = 0;
   int         last_lat = 0;
   int         en_cnt = 0;
   int         fe_cnt = 0;
   logic       en_prev = 1'b0;
   logic       fe_prev = 1'b0;
   logic [7:0] cap[$];

   // transmitter model for the loopback step
   logic       tx_go = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_line = 1'b1;
   logic       tx_act = 1'b0;
   logic [8:0] tx_sh = '0;
   int         tx_bits = 0;
   int         tx_cnt = 0;

   assign rx_w = loop ? tx_line : rx_bfm;

   always #5 clk = ~clk;

   uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .res        (res),
      .RX         (rx_w),
      .data_out   (data_out),
      .en_data_out(en_data_out),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!tx_act) begin
         if (tx_go) begin
            tx_act  <= 1'b1;
            tx_line <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_bits <= 9;
            tx_cnt  <= CPB - 1;
         end
      end else if (tx_cnt == 0) begin
         if (tx_bits == 0) begin
            tx_act <= 1'b0;
         end else begin
            tx_line <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_bits <= tx_bits - 1;
            tx_cnt  <= CPB - 1;
         end
      end else begin
         tx_cnt <= tx_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (en_prev || fe_prev) chk("strobe_width", {30'd0, en_data_out, frame_err}, 32'd0);
      if (en_data_out || frame_err) chk("strobe_excl", {31'd0, en_data_out & frame_err}, 32'd0);
      if (en_data_out) begin
         en_cnt++;
         last_lat = cyc - t_fall;
         cap.push_back(data_out);
      end
      if (frame_err) fe_cnt++;
      en_prev = en_data_out;
      fe_prev = frame_err;
   end

   task automatic send(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_bfm = 1'b0;
      t_fall = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_bfm = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_bfm = stop;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_bfm = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: reset state and quiet line
      #17 res = 1'b0;
      @(negedge clk);
      chk("rst_data", {24'd0, data_out}, 32'h00);
      chk("rst_en", {31'd0, en_data_out}, 32'd0);
      chk("rst_fe", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (200) @(negedge clk);
      chk("idle_en_cnt", en_cnt, 0);
      chk("idle_fe_cnt", fe_cnt, 0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // 2: single byte with latency window 78..80
      send(8'h0A, 1'b1);
      idle(20);
      chk("b0A_en_cnt", en_cnt, 1);
      chk("b0A_data", {24'd0, data_out}, 32'h0A);
      chk("b0A_fe_cnt", fe_cnt, 0);
      chk("b0A_lat_ok", {31'd0, (last_lat >= 78 && last_lat <= 80)}, 32'd1);
      chk("b0A_busy", {31'd0, busy}, 32'd0);

      // 4 (run while 0A is still the last good byte): stop bit forced low
      send(8'h3C, 1'b0);
      @(negedge clk);
      idle(30);
      chk("fe_fe_cnt", fe_cnt, 1);
      chk("fe_en_cnt", en_cnt, 1);
      chk("fe_data_kept", {24'd0, data_out}, 32'h0A);
      chk("fe_busy", {31'd0, busy}, 32'd0);

      // 3: back-to-back frames with a one-bit stop
      send(8'hA5, 1'b1);
      send(8'h5A, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h00, 1'b1);
      idle(30);
      chk("b2b_en_cnt", en_cnt, 5);
      chk("b2b_cap1", {24'd0, cap[1]}, 32'hA5);
      chk("b2b_cap2", {24'd0, cap[2]}, 32'h5A);
      chk("b2b_cap3", {24'd0, cap[3]}, 32'hFF);
      chk("b2b_cap4", {24'd0, cap[4]}, 32'h00);
      chk("b2b_fe_cnt", fe_cnt, 1);

      // 5: 3-clk glitch is rejected, then a valid byte
      @(negedge clk);
      rx_bfm = 1'b0;
      repeat (3) @(negedge clk);
      rx_bfm = 1'b1;
      @(negedge clk);
      chk("gl_busy_hi", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge clk);
      chk("gl_busy_lo", {31'd0, busy}, 32'd0);
      chk("gl_en_cnt", en_cnt, 5);
      chk("gl_fe_cnt", fe_cnt, 1);
      send(8'h81, 1'b1);
      idle(20);
      chk("b81_en_cnt", en_cnt, 6);
      chk("b81_data", {24'd0, data_out}, 32'h81);

      // 6: reset during bit 4 of C3, then a full 96
      fork
         send(8'hC3, 1'b1);
         begin
            repeat (CPB * 5 + 3) @(negedge clk);
            res = 1'b1;
            @(negedge clk);
            res = 1'b0;
            @(negedge clk);
            chk("mr_data_rst", {24'd0, data_out}, 32'h00);
            chk("mr_busy_rst", {31'd0, busy}, 32'd0);
         end
      join
      idle(30);
      chk("mr_en_cnt", en_cnt, 6);
      chk("mr_fe_cnt", fe_cnt, 1);
      send(8'h96, 1'b1);
      idle(20);
      chk("b96_en_cnt", en_cnt, 7);
      chk("b96_data", {24'd0, data_out}, 32'h96);

      // 7: loopback from the transmitter model
      loop = 1'b1;
      @(negedge clk);
      tx_data = 8'h0A;
      tx_go   = 1'b1;
      @(negedge clk);
      tx_go   = 1'b0;
      repeat (110) @(negedge clk);
      chk("lb_en_cnt", en_cnt, 8);
      chk("lb_data", {24'd0, data_out}, 32'h0A);
      chk("lb_fe_cnt", fe_cnt, 1);
      chk("cap_size", cap.size(), 8);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
